// File: rtl/player_motion_ctrl_pkg.sv
// Shared state encoding and default tuning constants for the dino player controller.
package player_motion_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_RESTART   = 3'd0,
    ST_JUMPING   = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_DUCKING   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  localparam int DEF_POS_W             = 8;
  localparam int DEF_VEL_W             = 6;
  localparam int DEF_JUMP_VELOCITY     = 12;
  localparam int DEF_GRAVITY           = 1;
  localparam int DEF_FAST_DROP_ACCEL   = 3;
  localparam int DEF_JUMP_CUT_VELOCITY = 4;
  localparam int DEF_MAX_HEIGHT        = 100;
  localparam int DEF_RESTART_HOLDOFF   = 8;
endpackage

// File: rtl/player_motion_ctrl_if.sv
// Player controller I/O bundle: tick/button/crash inputs, renderer and score outputs.
interface player_motion_ctrl_if #(parameter int POS_W = 8);
  logic [1:0]       game_tick;
  logic             button_up;
  logic             button_down;
  logic             crash;
  logic [POS_W-1:0] player_position;
  logic [2:0]       player_state;
  logic             jumping;
  logic             ducking;
  logic             game_start_pulse;
  logic             game_over_pulse;
  logic             jump_pulse;
  logic             land_pulse;

  modport master (
    output game_tick, button_up, button_down, crash,
    input  player_position, player_state, jumping, ducking,
           game_start_pulse, game_over_pulse, jump_pulse, land_pulse
  );
  modport slave (
    input  game_tick, button_up, button_down, crash,
    output player_position, player_state, jumping, ducking,
           game_start_pulse, game_over_pulse, jump_pulse, land_pulse
  );
endinterface

// File: rtl/player_motion_ctrl_physics_core.sv
// Jump integrator: velocity/position update with jump cut, fast drop, ceiling clamp and landing detect.
module player_physics_core #(
  parameter int POS_W             = 8,
  parameter int VEL_W             = 6,
  parameter int JUMP_VELOCITY     = 12,
  parameter int GRAVITY           = 1,
  parameter int FAST_DROP_ACCEL   = 3,
  parameter int JUMP_CUT_VELOCITY = 4,
  parameter int MAX_HEIGHT        = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic             up,
  input  logic             down,
  output logic [POS_W-1:0] pos,
  output logic             land
);
  // Wide enough that pos+vel and vel-accel never wrap before the clamps look at them.
  localparam int W = ((POS_W > VEL_W) ? POS_W : VEL_W) + 2;
  localparam logic signed [VEL_W-1:0] CUT_V  = VEL_W'(JUMP_CUT_VELOCITY);
  localparam logic signed [W-1:0]     MAX_W  = W'(MAX_HEIGHT);
  localparam logic signed [W-1:0]     ZERO_W = '0;
  localparam logic signed [W-1:0]     VMIN_W = -(W'(1) <<< (VEL_W-1));

  logic signed [VEL_W-1:0] vel_q, vel_d, vel_eff;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic signed [W-1:0]     pos_w, vel_w, p_w, v_w;

  always_comb begin
    vel_eff = vel_q;
    if (!up && (vel_q > CUT_V)) vel_eff = CUT_V;
    pos_w = W'(pos_q);
    vel_w = W'(vel_eff);
    p_w   = pos_w + vel_w;
    v_w   = vel_w - (down ? W'(FAST_DROP_ACCEL) : W'(GRAVITY));
    if (v_w < VMIN_W) v_w = VMIN_W;
  end

  assign land = step && (p_w <= ZERO_W);

  always_comb begin
    pos_d = pos_q;
    vel_d = vel_q;
    if (clear) begin
      pos_d = '0;
      vel_d = '0;
    end else if (load) begin
      pos_d = '0;
      vel_d = VEL_W'(JUMP_VELOCITY);
    end else if (step) begin
      if (p_w > MAX_W) begin
        pos_d = POS_W'(MAX_HEIGHT);
        vel_d = '0;
      end else if (p_w <= ZERO_W) begin
        pos_d = '0;
        vel_d = '0;
      end else begin
        pos_d = p_w[POS_W-1:0];
        vel_d = v_w[VEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      vel_q <= '0;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end

  assign pos = pos_q;
endmodule

// File: rtl/player_motion_ctrl.sv
// Dino player controller: game-state FSM, restart hold-off and event pulses around the physics core.
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
#(
  parameter int POS_W             = DEF_POS_W,
  parameter int VEL_W             = DEF_VEL_W,
  parameter int JUMP_VELOCITY     = DEF_JUMP_VELOCITY,
  parameter int GRAVITY           = DEF_GRAVITY,
  parameter int FAST_DROP_ACCEL   = DEF_FAST_DROP_ACCEL,
  parameter int JUMP_CUT_VELOCITY = DEF_JUMP_CUT_VELOCITY,
  parameter int MAX_HEIGHT        = DEF_MAX_HEIGHT,
  parameter int RESTART_HOLDOFF   = DEF_RESTART_HOLDOFF
) (
  input logic                clk,
  input logic                reset,
  player_motion_ctrl_if.slave io
);
  localparam int HW = $clog2(RESTART_HOLDOFF + 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   holdoff_q, holdoff_d;
  logic            up_s_q, up_s_d, down_s_q, down_s_d;
  logic            start_q, start_d, over_q, over_d, jump_q, jump_d, land_q, land_d;
  logic            tick0, tick1, load, clear, step, land;
  logic [POS_W-1:0] pos;

  // A tick[1] coinciding with tick[0] is dropped so the sampled inputs stay coherent.
  assign tick0 = io.game_tick[0];
  assign tick1 = io.game_tick[1] && !io.game_tick[0];
  assign step  = (state_q == ST_JUMPING) && tick1;

  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    up_s_d    = up_s_q;
    down_s_d  = down_s_q;
    start_d   = 1'b0;
    over_d    = 1'b0;
    jump_d    = 1'b0;
    land_d    = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    if (tick0) begin
      up_s_d   = io.button_up;
      down_s_d = io.button_down;
    end
    case (state_q)
      ST_RESTART: if (tick0 && io.button_up) begin
        state_d = ST_JUMPING;
        start_d = 1'b1;
        jump_d  = 1'b1;
        load    = 1'b1;
      end
      ST_RUNNING: if (tick0) begin
        if (io.crash) begin
          state_d   = ST_GAME_OVER;
          holdoff_d = HW'(RESTART_HOLDOFF);
          over_d    = 1'b1;
        end else if (io.button_down) begin
          state_d = ST_DUCKING;
        end else if (io.button_up) begin
          state_d = ST_JUMPING;
          jump_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_DUCKING: if (tick0) begin
        if (io.crash) begin
          state_d   = ST_GAME_OVER;
          holdoff_d = HW'(RESTART_HOLDOFF);
          over_d    = 1'b1;
        end else if (!io.button_down) begin
          state_d = ST_RUNNING;
        end
      end
      ST_JUMPING: begin
        if (tick0 && io.crash) begin
          state_d   = ST_GAME_OVER;
          holdoff_d = HW'(RESTART_HOLDOFF);
          over_d    = 1'b1;
        end else if (land) begin
          state_d = down_s_q ? ST_DUCKING : ST_RUNNING;
          land_d  = 1'b1;
        end
      end
      ST_GAME_OVER: if (tick0) begin
        if (holdoff_q != '0) begin
          holdoff_d = holdoff_q - HW'(1);
        end else if (io.button_up) begin
          state_d = ST_RUNNING;
          clear   = 1'b1;
        end
      end
      default: state_d = ST_RESTART;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESTART;
      holdoff_q <= '0;
      up_s_q    <= 1'b0;
      down_s_q  <= 1'b0;
      start_q   <= 1'b0;
      over_q    <= 1'b0;
      jump_q    <= 1'b0;
      land_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      up_s_q    <= up_s_d;
      down_s_q  <= down_s_d;
      start_q   <= start_d;
      over_q    <= over_d;
      jump_q    <= jump_d;
      land_q    <= land_d;
    end
  end

  player_physics_core #(
    .POS_W(POS_W), .VEL_W(VEL_W), .JUMP_VELOCITY(JUMP_VELOCITY), .GRAVITY(GRAVITY),
    .FAST_DROP_ACCEL(FAST_DROP_ACCEL), .JUMP_CUT_VELOCITY(JUMP_CUT_VELOCITY),
    .MAX_HEIGHT(MAX_HEIGHT)
  ) u_phys (
    .clk(clk), .reset(reset), .load(load), .step(step), .clear(clear),
    .up(up_s_q), .down(down_s_q), .pos(pos), .land(land)
  );

  assign io.player_position  = pos;
  assign io.player_state     = state_q;
  assign io.jumping          = (state_q == ST_JUMPING);
  assign io.ducking          = (state_q == ST_DUCKING);
  assign io.game_start_pulse = start_q;
  assign io.game_over_pulse  = over_q;
  assign io.jump_pulse       = jump_q;
  assign io.land_pulse       = land_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench: each issued tick pushes the expected state/position/pulses; a monitor checks them.
module tb_player_motion_ctrl;
  localparam logic [2:0] S_RST = 3'd0, S_JMP = 3'd1, S_RUN = 3'd2, S_DCK = 3'd3, S_GO = 3'd4;
  localparam logic [3:0] P_START = 4'b1000, P_OVER = 4'b0100, P_JUMP = 4'b0010, P_LAND = 4'b0001;

  typedef struct {
    logic [2:0] st;
    logic [7:0] pos;
    logic [3:0] pl;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst2, sel;
  logic [1:0] game_tick;
  logic up, down, crash;
  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;
  int cur_pos = 0;

  int full_tbl [0:24] = '{12,23,33,42,50,57,63,68,72,75,77,78,78,77,75,72,68,63,57,50,42,33,23,12,0};
  int drop_tbl [0:6]  = '{78,75,69,60,48,33,15};
  int var_tbl  [0:13] = '{12,23,27,30,32,33,33,32,30,27,23,18,12,5};
  int ceil_tbl [0:6]  = '{31,61,90,100,100,99,97};

  always #5 clk = ~clk;

  player_motion_ctrl_if #(.POS_W(8)) if1 ();
  player_motion_ctrl_if #(.POS_W(8)) if2 ();

  assign if1.game_tick = game_tick;  assign if2.game_tick = game_tick;
  assign if1.button_up = up;         assign if2.button_up = up;
  assign if1.button_down = down;     assign if2.button_down = down;
  assign if1.crash = crash;          assign if2.crash = crash;

  player_motion_ctrl dut (.clk(clk), .reset(rst1), .io(if1));
  player_motion_ctrl #(.JUMP_VELOCITY(31), .MAX_HEIGHT(100)) dut_ceil (.clk(clk), .reset(rst2), .io(if2));

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Called at a negedge: issue one tick cycle and queue what the DUT must show after it.
  task automatic tk(input logic [1:0] t, input logic [2:0] st, input int pos, input logic [3:0] pl);
    exp_t e;
    e.st = st; e.pos = pos[7:0]; e.pl = pl;
    exp_q.push_back(e);
    game_tick = t;
    @(negedge clk);
    game_tick = 2'b00;
    cur_pos = pos;
  endtask

  task automatic jstep(input int pos, input logic [2:0] st, input logic [3:0] pl);
    tk(2'b01, S_JMP, cur_pos, 4'b0000);
    tk(2'b10, st, pos, pl);
  endtask

  initial begin : monitor
    bit t, s, r;
    exp_t e;
    logic [2:0] ast;
    logic [7:0] apos;
    logic [3:0] apl;
    logic aj, ad;
    forever begin
      @(posedge clk);
      t = |game_tick; s = sel; r = s ? rst2 : rst1;
      @(negedge clk);
      if (!r) begin
        if (s) begin
          ast = if2.player_state; apos = if2.player_position; aj = if2.jumping; ad = if2.ducking;
          apl = {if2.game_start_pulse, if2.game_over_pulse, if2.jump_pulse, if2.land_pulse};
        end else begin
          ast = if1.player_state; apos = if1.player_position; aj = if1.jumping; ad = if1.ducking;
          apl = {if1.game_start_pulse, if1.game_over_pulse, if1.jump_pulse, if1.land_pulse};
        end
        if (t) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("state", int'(ast), int'(e.st));
            chk("position", int'(apos), int'(e.pos));
            chk("pulses", int'(apl), int'(e.pl));
            chk("jumping_flag", int'(aj), int'(e.st == S_JMP));
            chk("ducking_flag", int'(ad), int'(e.st == S_DCK));
          end
        end else begin
          chk("stray_pulse", int'(apl), 0);
        end
      end
    end
  end

  initial begin : stim
    rst1 = 1'b1; rst2 = 1'b1; sel = 1'b0;
    game_tick = 2'b00; up = 1'b0; down = 1'b0; crash = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(if1.player_state), 0);
    chk("reset_pos", int'(if1.player_position), 0);
    chk("reset_pulses", int'({if1.game_start_pulse, if1.game_over_pulse, if1.jump_pulse, if1.land_pulse}), 0);
    rst1 = 1'b0;

    // Idle in RESTART without a button.
    tk(2'b01, S_RST, 0, 4'b0000);
    tk(2'b10, S_RST, 0, 4'b0000);

    // Full jump with up held throughout.
    up = 1'b1;
    tk(2'b01, S_JMP, 0, P_START | P_JUMP);
    for (int k = 0; k < 24; k++) jstep(full_tbl[k], S_JMP, 4'b0000);
    jstep(0, S_RUN, P_LAND);

    // Fast drop from the peak, landing while ducking.
    tk(2'b01, S_JMP, 0, P_JUMP);
    for (int k = 0; k < 12; k++) jstep(full_tbl[k], S_JMP, 4'b0000);
    down = 1'b1;
    for (int k = 0; k < 7; k++) jstep(drop_tbl[k], S_JMP, 4'b0000);
    jstep(0, S_DCK, P_LAND);
    up = 1'b0; down = 1'b0;
    tk(2'b01, S_RUN, 0, 4'b0000);
    down = 1'b1;
    tk(2'b01, S_DCK, 0, 4'b0000);
    down = 1'b0;
    tk(2'b01, S_RUN, 0, 4'b0000);

    // Variable jump height, with a simultaneous tick[0]/tick[1] mid-air.
    up = 1'b1;
    tk(2'b01, S_JMP, 0, P_JUMP);
    for (int k = 0; k < 14; k++) begin
      if (k == 2) up = 1'b0;
      jstep(var_tbl[k], S_JMP, 4'b0000);
      if (k == 5) tk(2'b11, S_JMP, 33, 4'b0000);
    end
    jstep(0, S_RUN, P_LAND);

    // Crash beats down and up; restart hold-off.
    up = 1'b1; down = 1'b1; crash = 1'b1;
    tk(2'b01, S_GO, 0, P_OVER);
    crash = 1'b0;
    repeat (8) tk(2'b01, S_GO, 0, 4'b0000);
    tk(2'b10, S_GO, 0, 4'b0000);
    tk(2'b01, S_RUN, 0, 4'b0000);

    // Mid-air crash freezes position until restart.
    down = 1'b0;
    tk(2'b01, S_JMP, 0, P_JUMP);
    jstep(12, S_JMP, 4'b0000);
    jstep(23, S_JMP, 4'b0000);
    crash = 1'b1;
    tk(2'b01, S_GO, 23, P_OVER);
    crash = 1'b0; up = 1'b0;
    tk(2'b10, S_GO, 23, 4'b0000);
    up = 1'b1;
    repeat (8) tk(2'b01, S_GO, 23, 4'b0000);
    tk(2'b01, S_RUN, 0, 4'b0000);

    // Reset mid-jump at height 42.
    tk(2'b01, S_JMP, 0, P_JUMP);
    for (int k = 0; k < 4; k++) jstep(full_tbl[k], S_JMP, 4'b0000);
    rst1 = 1'b1;
    @(negedge clk);
    chk("midjump_reset_state", int'(if1.player_state), 0);
    chk("midjump_reset_pos", int'(if1.player_position), 0);
    chk("midjump_reset_pulses", int'({if1.game_start_pulse, if1.game_over_pulse, if1.jump_pulse, if1.land_pulse}), 0);
    rst1 = 1'b0;
    up = 1'b0;
    tk(2'b01, S_RST, 0, 4'b0000);
    up = 1'b1;
    tk(2'b01, S_JMP, 0, P_START | P_JUMP);

    // Ceiling clamp on the high-velocity instance.
    rst1 = 1'b1; sel = 1'b1; rst2 = 1'b0;
    tk(2'b01, S_JMP, 0, P_START | P_JUMP);
    for (int k = 0; k < 7; k++) jstep(ceil_tbl[k], S_JMP, 4'b0000);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
